round_scheduler: RTL and testbench



---
 rtl/game_pkg.sv | 34 +++
 rtl/round_scheduler_if.sv | 29 ++
 rtl/lfsr16.sv | 20 ++
 rtl/round_scheduler.sv | 160 ++++++++++++++++
 tb/tb_round_scheduler.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types, widths and helpers for the round scheduler.
//   state_t     : scheduler FSM states
//   popcount16  : number of set bits in a 16-bit cell mask
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SPAWN     = 3'd1,
    ACTIVE    = 3'd2,
    ROUND_END = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam int unsigned GRID_CELLS = 16;
  localparam int unsigned POS_W      = 4;
  localparam int unsigned SIZE_W     = 29;
  localparam int unsigned NUMS_W     = 3;
  localparam int unsigned NUMS_MAX   = 3;
  localparam int unsigned PLACED_W   = 2;
  localparam int unsigned SCORE_W    = 8;
  localparam int unsigned MISS_W     = 4;
  localparam int unsigned ROUND_W    = 8;
  localparam int unsigned CNT_W      = 5;

  function automatic logic [CNT_W-1:0] popcount16(input logic [GRID_CELLS-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(GRID_CELLS); i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/round_scheduler_if.sv
// Control/status bundle between the game front end and the round scheduler.
//   master : drives start/size/nums and the hit strobe, observes status
//   slave  : the scheduler side
interface round_scheduler_if;
  import game_pkg::*;

  logic                  start;
  logic [SIZE_W-1:0]     size;
  logic [NUMS_W-1:0]     nums;
  logic                  hit_valid;
  logic [POS_W-1:0]      hit_pos;
  logic [GRID_CELLS-1:0] target_mask;
  logic [SCORE_W-1:0]    score;
  logic [MISS_W-1:0]     misses;
  logic [ROUND_W-1:0]    round_num;
  logic                  busy;
  logic                  game_over;

  modport master (
    output start, size, nums, hit_valid, hit_pos,
    input  target_mask, score, misses, round_num, busy, game_over
  );

  modport slave (
    input  start, size, nums, hit_valid, hit_pos,
    output target_mask, score, misses, round_num, busy, game_over
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
//   clk, reset : clock and synchronous active-high reset (loads SEED)
//   state      : current LFSR value
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED;
    end else begin
      state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
    end
  end

endmodule

// File: rtl/round_scheduler.sv
// Sequences game rounds: places distinct targets, times each round,
// scores hits and counts expired targets.
//   clk, reset : clock and synchronous active-high reset
//   bus        : start/size/nums/hit inputs; mask, score, misses,
//                round_num, busy, game_over outputs (all registered)
module round_scheduler
  import game_pkg::*;
#(
  parameter int unsigned ROUNDS     = 20,
  parameter int unsigned MAX_MISSES = 5,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic           clk,
  input  logic           reset,
  round_scheduler_if.slave bus
);

  state_t                state_q, state_d;
  logic [GRID_CELLS-1:0] lfsr_q;
  logic [GRID_CELLS-1:0] mask_q, mask_d, mask_after;
  logic [SIZE_W-1:0]     size_q, size_d, timer_q, timer_d;
  logic [PLACED_W-1:0]   nums_q, nums_d, placed_q, placed_d, placed_next;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic [MISS_W-1:0]     misses_q, misses_d;
  logic [ROUND_W-1:0]    round_q, round_d;
  logic                  busy_q, busy_d, over_q, over_d;
  logic [POS_W-1:0]      cand;
  logic                  hit_ok;
  logic [CNT_W-1:0]      miss_sum;
  logic                  unused_lfsr_hi;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr_q)
  );

  assign cand           = lfsr_q[POS_W-1:0];
  assign unused_lfsr_hi = ^lfsr_q[GRID_CELLS-1:POS_W];

  // A hit on a lit cell is removed before timeout misses are counted.
  assign hit_ok     = bus.hit_valid && mask_q[bus.hit_pos];
  assign mask_after = hit_ok ? (mask_q & ~(GRID_CELLS'(1) << bus.hit_pos)) : mask_q;
  assign miss_sum   = CNT_W'(misses_q) + popcount16(mask_after);

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    size_d      = size_q;
    timer_d     = timer_q;
    nums_d      = nums_q;
    placed_d    = placed_q;
    placed_next = placed_q + PLACED_W'(1);
    score_d     = score_q;
    misses_d    = misses_q;
    round_d     = round_q;

    case (state_q)
      IDLE, DONE: begin
        mask_d = '0;
        if (bus.start) begin
          size_d = (bus.size == '0) ? SIZE_W'(1) : bus.size;
          if (bus.nums == '0) begin
            nums_d = PLACED_W'(1);
          end else if (bus.nums > NUMS_W'(NUMS_MAX)) begin
            nums_d = PLACED_W'(NUMS_MAX);
          end else begin
            nums_d = bus.nums[PLACED_W-1:0];
          end
          score_d  = '0;
          misses_d = '0;
          round_d  = '0;
          placed_d = '0;
          state_d  = SPAWN;
        end
      end

      SPAWN: begin
        // Occupied candidates are simply retried with the next LFSR value.
        if (!mask_q[cand]) begin
          mask_d[cand] = 1'b1;
          placed_d     = placed_next;
          if (placed_next == nums_q) begin
            timer_d = size_q - SIZE_W'(1);
            state_d = ACTIVE;
          end
        end
      end

      ACTIVE: begin
        if (hit_ok) begin
          mask_d  = mask_after;
          score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
        end
        if (mask_after == '0) begin
          state_d = ROUND_END;
        end else if (timer_q == '0) begin
          misses_d = miss_sum[CNT_W-1] ? '1 : miss_sum[MISS_W-1:0];
          state_d  = ROUND_END;
        end else begin
          timer_d = timer_q - SIZE_W'(1);
        end
      end

      ROUND_END: begin
        mask_d   = '0;
        placed_d = '0;
        round_d  = round_q + ROUND_W'(1);
        if (round_d == ROUND_W'(ROUNDS) || misses_q >= MISS_W'(MAX_MISSES)) begin
          state_d = DONE;
        end else begin
          state_d = SPAWN;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SPAWN) || (state_d == ACTIVE) || (state_d == ROUND_END);
    over_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      size_q   <= '0;
      timer_q  <= '0;
      nums_q   <= '0;
      placed_q <= '0;
      score_q  <= '0;
      misses_q <= '0;
      round_q  <= '0;
      busy_q   <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      size_q   <= size_d;
      timer_q  <= timer_d;
      nums_q   <= nums_d;
      placed_q <= placed_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      round_q  <= round_d;
      busy_q   <= busy_d;
      over_q   <= over_d;
    end
  end

  assign bus.target_mask = mask_q;
  assign bus.score       = score_q;
  assign bus.misses      = misses_q;
  assign bus.round_num   = round_q;
  assign bus.busy        = busy_q;
  assign bus.game_over   = over_q;

endmodule

// File: tb/tb_round_scheduler.sv
// Directed self-checking bench for round_scheduler.
module tb_round_scheduler;
  import game_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  round_scheduler_if bus ();

  round_scheduler #(
    .ROUNDS     (20),
    .MAX_MISSES (5),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input state_t st, input int budget);
    int n = 0;
    while (dut.state_q != st && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (dut.state_q != st) begin
      failures++;
      $display("FAIL wait_%s: state=%s after %0d cycles, required %s",
               st.name(), dut.state_q.name(), n, st.name());
    end
  endtask

  task automatic pulse_start(input logic [SIZE_W-1:0] sz, input logic [NUMS_W-1:0] n);
    bus.start = 1'b1;
    bus.size  = sz;
    bus.nums  = n;
    step();
    bus.start = 1'b0;
  endtask

  task automatic hit(input logic [POS_W-1:0] pos);
    bus.hit_valid = 1'b1;
    bus.hit_pos   = pos;
    step();
    bus.hit_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [POS_W-1:0] lowest_set(input logic [GRID_CELLS-1:0] m);
    logic [POS_W-1:0] r = '0;
    for (int i = 15; i >= 0; i--) if (m[i]) r = POS_W'(i);
    return r;
  endfunction

  function automatic logic [POS_W-1:0] lowest_clear(input logic [GRID_CELLS-1:0] m);
    logic [POS_W-1:0] r = '0;
    for (int i = 15; i >= 0; i--) if (!m[i]) r = POS_W'(i);
    return r;
  endfunction

  task automatic test_reset_initial();
    checks++;
    if ({bus.target_mask, bus.score, bus.misses, bus.round_num, bus.busy, bus.game_over} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: mask=%h score=%0d misses=%0d round=%0d busy=%b over=%b, required all 0",
               bus.target_mask, bus.score, bus.misses, bus.round_num, bus.busy, bus.game_over);
    end
    checks++;
    if (dut.state_q != IDLE || dut.lfsr_q !== 16'hACE1) begin
      failures++;
      $display("FAIL reset_state: state=%s lfsr=%h, required IDLE ace1", dut.state_q.name(), dut.lfsr_q);
    end
  endtask

  task automatic test_early_clear();
    pulse_start(29'd1000, 3'd3);
    checks++;
    if (bus.busy !== 1'b1 || dut.state_q != SPAWN) begin
      failures++;
      $display("FAIL start_spawn: busy=%b state=%s, required 1 SPAWN", bus.busy, dut.state_q.name());
    end
    wait_state(ACTIVE, 50);
    checks++;
    if ($countones(bus.target_mask) != 3) begin
      failures++;
      $display("FAIL early_mask: mask=%h, required 3 bits", bus.target_mask);
    end
    for (int k = 0; k < 3; k++) hit(lowest_set(bus.target_mask));
    checks++;
    if (dut.state_q != ROUND_END || bus.score !== 8'd3 || bus.misses !== 4'd0) begin
      failures++;
      $display("FAIL early_clear: state=%s score=%0d misses=%0d, required ROUND_END 3 0",
               dut.state_q.name(), bus.score, bus.misses);
    end
    step();
    checks++;
    if (dut.state_q != SPAWN || bus.round_num !== 8'd1 || bus.target_mask !== '0) begin
      failures++;
      $display("FAIL early_next: state=%s round=%0d mask=%h, required SPAWN 1 0",
               dut.state_q.name(), bus.round_num, bus.target_mask);
    end
  endtask

  task automatic test_reset_midgame();
    wait_state(ACTIVE, 50);
    checks++;
    if (bus.score !== 8'd3) begin
      failures++;
      $display("FAIL mid_score: score=%0d, required 3", bus.score);
    end
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({bus.target_mask, bus.score, bus.misses, bus.round_num, bus.busy, bus.game_over} !== '0
        || dut.state_q != IDLE || dut.lfsr_q !== 16'hACE1) begin
      failures++;
      $display("FAIL mid_reset: mask=%h score=%0d misses=%0d round=%0d busy=%b state=%s lfsr=%h, required zeros IDLE ace1",
               bus.target_mask, bus.score, bus.misses, bus.round_num, bus.busy, dut.state_q.name(), dut.lfsr_q);
    end
    reset = 1'b0;
  endtask

  task automatic test_clamp();
    pulse_start(29'd5, 3'd0);
    wait_state(ACTIVE, 50);
    checks++;
    if ($countones(bus.target_mask) != 1) begin
      failures++;
      $display("FAIL clamp_low: mask=%h, required 1 bit", bus.target_mask);
    end
    pulse_reset();
    pulse_start(29'd8, 3'd7);
    for (int r = 0; r < 50; r++) begin
      wait_state(ACTIVE, 100);
      checks++;
      if ($countones(bus.target_mask) != 3) begin
        failures++;
        $display("FAIL clamp_high round %0d: mask=%h, required 3 bits", r, bus.target_mask);
      end
      for (int k = 0; k < 3; k++) hit(lowest_set(bus.target_mask));
      step();
      if (dut.state_q == DONE) pulse_start(29'd8, 3'd7);
    end
  endtask

  task automatic test_timeout();
    pulse_reset();
    pulse_start(29'd10, 3'd2);
    for (int r = 1; r <= 3; r++) begin
      int cnt = 0;
      wait_state(ACTIVE, 50);
      while (dut.state_q == ACTIVE && cnt < 100) begin
        cnt++;
        step();
      end
      checks++;
      if (cnt != 10 || bus.misses !== 4'(2 * r)) begin
        failures++;
        $display("FAIL timeout round %0d: active=%0d misses=%0d, required 10 %0d", r, cnt, bus.misses, 2 * r);
      end
      step();
      checks++;
      if (r < 3) begin
        if (dut.state_q != SPAWN || bus.round_num !== 8'(r)) begin
          failures++;
          $display("FAIL timeout_next round %0d: state=%s round=%0d, required SPAWN %0d",
                   r, dut.state_q.name(), bus.round_num, r);
        end
      end else if (dut.state_q != DONE || bus.game_over !== 1'b1 || bus.busy !== 1'b0
                   || bus.round_num !== 8'd3 || bus.misses !== 4'd6) begin
        failures++;
        $display("FAIL timeout_end: state=%s over=%b busy=%b round=%0d misses=%0d, required DONE 1 0 3 6",
                 dut.state_q.name(), bus.game_over, bus.busy, bus.round_num, bus.misses);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [POS_W-1:0] pos;
    pulse_reset();
    pulse_start(29'd10, 3'd1);
    wait_state(ACTIVE, 50);
    pos = lowest_set(bus.target_mask);
    repeat (9) step();
    checks++;
    if (dut.state_q != ACTIVE || dut.timer_q !== '0) begin
      failures++;
      $display("FAIL sim_timer: state=%s timer=%0d, required ACTIVE 0", dut.state_q.name(), dut.timer_q);
    end
    hit(pos);
    checks++;
    if (dut.state_q != ROUND_END || bus.score !== 8'd1 || bus.misses !== 4'd0) begin
      failures++;
      $display("FAIL sim_hit: state=%s score=%0d misses=%0d, required ROUND_END 1 0",
               dut.state_q.name(), bus.score, bus.misses);
    end
    step();
    wait_state(ACTIVE, 50);
    pos = lowest_clear(bus.target_mask);
    repeat (9) step();
    hit(pos);
    checks++;
    if (dut.state_q != ROUND_END || bus.score !== 8'd1 || bus.misses !== 4'd1) begin
      failures++;
      $display("FAIL sim_clear_hit: state=%s score=%0d misses=%0d, required ROUND_END 1 1",
               dut.state_q.name(), bus.score, bus.misses);
    end
  endtask

  task automatic test_full_game();
    pulse_reset();
    pulse_start(29'd4, 3'd1);
    for (int r = 1; r <= 20; r++) begin
      wait_state(ACTIVE, 50);
      hit(lowest_set(bus.target_mask));
      step();
      checks++;
      if (bus.round_num !== 8'(r) || bus.score !== 8'(r)) begin
        failures++;
        $display("FAIL full_round %0d: round=%0d score=%0d, required %0d %0d", r, bus.round_num, bus.score, r, r);
      end
    end
    checks++;
    if (dut.state_q != DONE || bus.game_over !== 1'b1 || bus.busy !== 1'b0 || bus.misses !== 4'd0
        || bus.target_mask !== '0) begin
      failures++;
      $display("FAIL full_end: state=%s over=%b busy=%b misses=%0d mask=%h, required DONE 1 0 0 0",
               dut.state_q.name(), bus.game_over, bus.busy, bus.misses, bus.target_mask);
    end
    pulse_start(29'd4, 3'd1);
    checks++;
    if (dut.state_q != SPAWN || bus.score !== 8'd0 || bus.misses !== 4'd0 || bus.round_num !== 8'd0
        || bus.game_over !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL restart: state=%s score=%0d misses=%0d round=%0d over=%b busy=%b, required SPAWN 0 0 0 0 1",
               dut.state_q.name(), bus.score, bus.misses, bus.round_num, bus.game_over, bus.busy);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.size      = '0;
    bus.nums      = '0;
    bus.hit_valid = 1'b0;
    bus.hit_pos   = '0;
    step();
    step();
    test_reset_initial();
    reset = 1'b0;
    test_early_clear();
    test_reset_midgame();
    test_clamp();
    test_timeout();
    test_simultaneous();
    test_full_game();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
